// File: rtl/cpu_pc_stack.sv
// -----------------------------------------------------------------------------
// cpu_pc_stack
// -----------------------------------------------------------------------------
// Program-counter register for the fetch path with a configurable increment
// step, a hardware return-address stack (call/ret) and an error pulse for
// requests that are illegal or conflicting.
//
// Exactly one request per cycle is honoured. Two or more simultaneous
// requests, a call on a full stack, or a ret on an empty stack leave all
// state untouched and raise err for one cycle.
//
// Parameters
//   N        address width in bits
//   STEP     increment applied by inc, and the return offset pushed by call
//   DEPTH    number of return-stack entries (>= 1)
//   RST_VAL  program counter value after reset
//
// Ports
//   clk    in   rising-edge system clock
//   rst    in   synchronous reset, active-high, overrides every request
//   inc    in   q <= q + STEP
//   load   in   q <= d
//   call   in   push q + STEP, then q <= d
//   ret    in   q <= top of stack, then pop
//   d      in   load/call target, sampled only on load/call edges
//   q      out  current program counter (registered)
//   empty  out  stack holds no entries
//   full   out  stack holds DEPTH entries
//   err    out  one-cycle pulse after a rejected request
//   ovf    out  present only when CPU_PC_OVF_EN is defined: one-cycle pulse
//               after an accepted inc whose q + STEP carried out of N bits
//
// Build option
//   CPU_PC_OVF_EN  adds the ovf port and its carry detection. Without it the
//                  increment wraps silently.
// -----------------------------------------------------------------------------
module cpu_pc_stack #(
    parameter int unsigned N       = 8,
    parameter int unsigned STEP    = 1,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned RST_VAL = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         load,
    input  logic         call,
    input  logic         ret,
    input  logic [N-1:0] d,
    output logic [N-1:0] q,
    output logic         empty,
    output logic         full,
`ifdef CPU_PC_OVF_EN
    output logic         ovf,
`endif
    output logic         err
);

    // sp counts occupied entries (0..DEPTH); the entry index needs one bit less
    // whenever DEPTH is a power of two.
    localparam int unsigned SP_W  = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [N-1:0]    pc_q,  pc_d;
    logic [SP_W-1:0] sp_q,  sp_d;
    logic            err_q, err_d;
    logic [N-1:0]    stack_mem [0:DEPTH-1];

    logic [N-1:0]    ret_addr;   // q + STEP, wrapped to N bits
    logic [SP_W-1:0] sp_m1;      // index of the top-of-stack entry
    logic            stack_empty;
    logic            stack_full;
    logic            push_en;

`ifdef CPU_PC_OVF_EN
    logic            ovf_q, ovf_d;
    logic [N:0]      inc_sum;

    // Extra top bit captures the carry out of the N-bit increment.
    assign inc_sum  = {1'b0, pc_q} + (N+1)'(STEP);
    assign ret_addr = inc_sum[N-1:0];
`else
    assign ret_addr = pc_q + N'(STEP);
`endif

    assign sp_m1       = sp_q - SP_W'(1);
    assign stack_empty = (sp_q == '0);
    assign stack_full  = (sp_q == SP_W'(DEPTH));

    // -------------------------------------------------------------------------
    // Next-state decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        pc_d    = pc_q;
        sp_d    = sp_q;
        err_d   = 1'b0;
        push_en = 1'b0;
`ifdef CPU_PC_OVF_EN
        ovf_d   = 1'b0;
`endif

        case ({inc, load, call, ret})
            4'b0000: ; // idle: hold everything
            4'b1000: begin
                pc_d = ret_addr;
`ifdef CPU_PC_OVF_EN
                ovf_d = inc_sum[N];
`endif
            end
            4'b0100: pc_d = d;
            4'b0010: begin
                if (stack_full) begin
                    err_d = 1'b1;
                end else begin
                    push_en = 1'b1;
                    sp_d    = sp_q + SP_W'(1);
                    pc_d    = d;
                end
            end
            4'b0001: begin
                if (stack_empty) begin
                    err_d = 1'b1;
                end else begin
                    pc_d = stack_mem[sp_m1[IDX_W-1:0]];
                    sp_d = sp_m1;
                end
            end
            // Any combination of two or more requests is rejected as a whole.
            default: err_d = 1'b1;
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= N'(RST_VAL);
            sp_q  <= '0;
            err_q <= 1'b0;
`ifdef CPU_PC_OVF_EN
            ovf_q <= 1'b0;
`endif
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            err_q <= err_d;
`ifdef CPU_PC_OVF_EN
            ovf_q <= ovf_d;
`endif
        end
    end

    // NOTE: the stack array is deliberately not reset; clearing sp alone makes
    // every entry unreachable, and leaving the array unreset lets it map onto
    // plain storage.
    always_ff @(posedge clk) begin
        if (push_en && !rst) begin
            stack_mem[sp_q[IDX_W-1:0]] <= ret_addr;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign q     = pc_q;
    assign empty = stack_empty;
    assign full  = stack_full;
    assign err   = err_q;
`ifdef CPU_PC_OVF_EN
    assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_cpu_pc_stack.sv
// -----------------------------------------------------------------------------
// tb_cpu_pc_stack
// -----------------------------------------------------------------------------
// Directed bench for cpu_pc_stack with N=8, STEP=1, DEPTH=4, RST_VAL=0.
// Inputs change 7 ns after a rising edge, outputs are sampled at that same
// point, so each tick() applies one cycle of requests and exposes its result.
// -----------------------------------------------------------------------------
module tb_cpu_pc_stack;

    logic       clk;
    logic       rst;
    logic       inc;
    logic       load;
    logic       call;
    logic       ret;
    logic [7:0] d;
    logic [7:0] q;
    logic       empty;
    logic       full;
    logic       err;
`ifdef CPU_PC_OVF_EN
    logic       ovf;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    cpu_pc_stack #(
        .N       (8),
        .STEP    (1),
        .DEPTH   (4),
        .RST_VAL (0)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc),
        .load  (load),
        .call  (call),
        .ret   (ret),
        .d     (d),
        .q     (q),
        .empty (empty),
        .full  (full),
`ifdef CPU_PC_OVF_EN
        .ovf   (ovf),
`endif
        .err   (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #7;
    endtask

    task automatic drive(input logic r, input logic i, input logic l,
                         input logic c, input logic t, input logic [7:0] dv);
        rst  = r;
        inc  = i;
        load = l;
        call = c;
        ret  = t;
        d    = dv;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h03);
        tick();
        tick();
        total_cnt++; if (q !== 8'h00) $display("FAIL reset_q: got %h want %h", q, 8'h00); else pass_cnt++;
        total_cnt++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty); else pass_cnt++;
        total_cnt++; if (full !== 1'b0) $display("FAIL reset_full: got %b want 0", full); else pass_cnt++;
        total_cnt++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else pass_cnt++;
`ifdef CPU_PC_OVF_EN
        total_cnt++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf); else pass_cnt++;
`endif
    endtask

    task automatic test_inc_load();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h03);
        tick();
        total_cnt++; if (q !== 8'h01) $display("FAIL inc_q: got %h want %h", q, 8'h01); else pass_cnt++;
        total_cnt++; if (err !== 1'b0) $display("FAIL inc_err: got %b want 0", err); else pass_cnt++;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h03);
        tick();
        total_cnt++; if (q !== 8'h03) $display("FAIL load_q: got %h want %h", q, 8'h03); else pass_cnt++;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h77);
        tick();
        total_cnt++; if (q !== 8'h03) $display("FAIL inc_load_q: got %h want %h", q, 8'h03); else pass_cnt++;
        total_cnt++; if (err !== 1'b1) $display("FAIL inc_load_err: got %b want 1", err); else pass_cnt++;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h77);
        tick();
        total_cnt++; if (err !== 1'b0) $display("FAIL err_clear: got %b want 0", err); else pass_cnt++;
        total_cnt++; if (q !== 8'h03) $display("FAIL idle_hold_q: got %h want %h", q, 8'h03); else pass_cnt++;
    endtask

    task automatic test_call_ret();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h40);
        tick();
        total_cnt++; if (q !== 8'h40) $display("FAIL call1_q: got %h want %h", q, 8'h40); else pass_cnt++;
        total_cnt++; if (empty !== 1'b0) $display("FAIL call1_empty: got %b want 0", empty); else pass_cnt++;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h80);
        tick();
        total_cnt++; if (q !== 8'h80) $display("FAIL call2_q: got %h want %h", q, 8'h80); else pass_cnt++;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        tick();
        total_cnt++; if (q !== 8'h41) $display("FAIL ret1_q: got %h want %h", q, 8'h41); else pass_cnt++;
        total_cnt++; if (empty !== 1'b0) $display("FAIL ret1_empty: got %b want 0", empty); else pass_cnt++;
        tick();
        total_cnt++; if (q !== 8'h04) $display("FAIL ret2_q: got %h want %h", q, 8'h04); else pass_cnt++;
        total_cnt++; if (empty !== 1'b1) $display("FAIL ret2_empty: got %b want 1", empty); else pass_cnt++;
        total_cnt++; if (err !== 1'b0) $display("FAIL ret2_err: got %b want 0", err); else pass_cnt++;
    endtask

    task automatic test_stack_limits();
        // Starting at q=4: calls to 0x20..0x23 push 0x05, 0x21, 0x22, 0x23.
        logic [7:0] call_tgt [4] = '{8'h20, 8'h21, 8'h22, 8'h23};
        logic [7:0] ret_exp  [4] = '{8'h23, 8'h22, 8'h21, 8'h05};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, call_tgt[i]);
            tick();
            total_cnt++; if (q !== call_tgt[i]) $display("FAIL fill_q[%0d]: got %h want %h", i, q, call_tgt[i]); else pass_cnt++;
        end
        total_cnt++; if (full !== 1'b1) $display("FAIL fill_full: got %b want 1", full); else pass_cnt++;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h10);
        tick();
        total_cnt++; if (q !== 8'h23) $display("FAIL overcall_q: got %h want %h", q, 8'h23); else pass_cnt++;
        total_cnt++; if (err !== 1'b1) $display("FAIL overcall_err: got %b want 1", err); else pass_cnt++;
        total_cnt++; if (full !== 1'b1) $display("FAIL overcall_full: got %b want 1", full); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
            tick();
            total_cnt++; if (q !== ret_exp[i]) $display("FAIL drain_q[%0d]: got %h want %h", i, q, ret_exp[i]); else pass_cnt++;
            total_cnt++; if (err !== 1'b0) $display("FAIL drain_err[%0d]: got %b want 0", i, err); else pass_cnt++;
        end
        total_cnt++; if (empty !== 1'b1) $display("FAIL drain_empty: got %b want 1", empty); else pass_cnt++;
        total_cnt++; if (full !== 1'b0) $display("FAIL drain_full: got %b want 0", full); else pass_cnt++;
        tick();
        total_cnt++; if (q !== 8'h05) $display("FAIL overret_q: got %h want %h", q, 8'h05); else pass_cnt++;
        total_cnt++; if (err !== 1'b1) $display("FAIL overret_err: got %b want 1", err); else pass_cnt++;
        total_cnt++; if (empty !== 1'b1) $display("FAIL overret_empty: got %b want 1", empty); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        // q=5, stack empty. call+ret and inc+call are both conflicts.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h60);
        tick();
        total_cnt++; if (q !== 8'h05) $display("FAIL call_ret_q: got %h want %h", q, 8'h05); else pass_cnt++;
        total_cnt++; if (err !== 1'b1) $display("FAIL call_ret_err: got %b want 1", err); else pass_cnt++;
        total_cnt++; if (empty !== 1'b1) $display("FAIL call_ret_empty: got %b want 1", empty); else pass_cnt++;
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h60);
        tick();
        total_cnt++; if (q !== 8'h05) $display("FAIL inc_call_q: got %h want %h", q, 8'h05); else pass_cnt++;
        total_cnt++; if (err !== 1'b1) $display("FAIL inc_call_err: got %b want 1", err); else pass_cnt++;
        // Accepted inc right after a rejection: err must drop.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h60);
        tick();
        total_cnt++; if (q !== 8'h06) $display("FAIL b2b_inc_q: got %h want %h", q, 8'h06); else pass_cnt++;
        total_cnt++; if (err !== 1'b0) $display("FAIL b2b_inc_err: got %b want 0", err); else pass_cnt++;
    endtask

    task automatic test_wrap();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF);
        tick();
        total_cnt++; if (q !== 8'hFF) $display("FAIL wrap_load_q: got %h want %h", q, 8'hFF); else pass_cnt++;
`ifdef CPU_PC_OVF_EN
        total_cnt++; if (ovf !== 1'b0) $display("FAIL wrap_load_ovf: got %b want 0", ovf); else pass_cnt++;
`endif
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        total_cnt++; if (q !== 8'h00) $display("FAIL wrap_inc_q: got %h want %h", q, 8'h00); else pass_cnt++;
        total_cnt++; if (err !== 1'b0) $display("FAIL wrap_inc_err: got %b want 0", err); else pass_cnt++;
`ifdef CPU_PC_OVF_EN
        total_cnt++; if (ovf !== 1'b1) $display("FAIL wrap_inc_ovf: got %b want 1", ovf); else pass_cnt++;
`endif
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF);
        tick();
`ifdef CPU_PC_OVF_EN
        total_cnt++; if (ovf !== 1'b0) $display("FAIL ovf_pulse: got %b want 0", ovf); else pass_cnt++;
`endif
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h30);
        tick();
        total_cnt++; if (q !== 8'h30) $display("FAIL wrap_call_q: got %h want %h", q, 8'h30); else pass_cnt++;
`ifdef CPU_PC_OVF_EN
        total_cnt++; if (ovf !== 1'b0) $display("FAIL wrap_call_ovf: got %b want 0", ovf); else pass_cnt++;
`endif
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        tick();
        total_cnt++; if (q !== 8'h00) $display("FAIL wrap_ret_q: got %h want %h", q, 8'h00); else pass_cnt++;
        total_cnt++; if (empty !== 1'b1) $display("FAIL wrap_ret_empty: got %b want 1", empty); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        // q=0: calls push 0x01 then 0x51.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h50);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h60);
        tick();
        total_cnt++; if (q !== 8'h60) $display("FAIL mid_pre_q: got %h want %h", q, 8'h60); else pass_cnt++;
        total_cnt++; if (empty !== 1'b0) $display("FAIL mid_pre_empty: got %b want 0", empty); else pass_cnt++;
        // Reset wins over a simultaneous inc.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        total_cnt++; if (q !== 8'h00) $display("FAIL mid_rst_q: got %h want %h", q, 8'h00); else pass_cnt++;
        total_cnt++; if (empty !== 1'b1) $display("FAIL mid_rst_empty: got %b want 1", empty); else pass_cnt++;
        total_cnt++; if (err !== 1'b0) $display("FAIL mid_rst_err: got %b want 0", err); else pass_cnt++;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        tick();
        total_cnt++; if (err !== 1'b1) $display("FAIL mid_ret_err: got %b want 1", err); else pass_cnt++;
        total_cnt++; if (q !== 8'h00) $display("FAIL mid_ret_q: got %h want %h", q, 8'h00); else pass_cnt++;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        test_reset();
        test_inc_load();
        test_call_ret();
        test_stack_limits();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
